// File: rtl/cs_measure_sequencer.sv
// -----------------------------------------------------------------------------
// cs_measure_sequencer
//
// Measurement sequencer for a TCS3200-style colour sensor. A start request
// steps the sensor through the red, green and blue filters. For each filter it
// waits a settle period, then counts rising edges of cs_out over a fixed
// window. It then classifies the dominant colour and holds the result under a
// result_valid / result_ack handshake.
//
// Optional feature macro: CS_AUTO_PWRDN_EN
//   When this macro is defined, cs_scaler is 00 (sensor powered down) in IDLE
//   and RESULT and 11 while measuring. The first settle period after leaving
//   IDLE or RESULT is stretched to 4*SETTLE so the sensor oscillator can wake
//   up. When it is undefined, cs_scaler stays at 11.
//
// Parameters
//   WINDOW   counting window per filter, clk cycles (>= 16)
//   SETTLE   discard cycles after each filter change (>= 3)
//   CNT_W    edge-counter width; counters saturate at all-ones
//   MIN_CNT  minimum winning count for a valid colour
//
// Ports
//   clk_1MHz      in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   cs_out        in   sensor frequency output (asynchronous)
//   start         in   measurement request (IDLE, or RESULT with result_ack)
//   busy          out  measurement in progress
//   filter        out  S2:S3 filter select (R=00 B=01 clear=10 G=11)
//   cs_scaler     out  S0:S1 frequency scaling
//   color         out  0=none 1=red 2=green 3=blue, valid with result_valid
//   red_cnt       out  raw red window count
//   green_cnt     out  raw green window count
//   blue_cnt      out  raw blue window count
//   result_valid  out  result held stable while high
//   result_ack    in   consumer acknowledge
// -----------------------------------------------------------------------------
module cs_measure_sequencer #(
   parameter int unsigned WINDOW  = 512,
   parameter int unsigned SETTLE  = 8,
   parameter int unsigned CNT_W   = 10,
   parameter int unsigned MIN_CNT = 15
) (
   input  logic             clk_1MHz,
   input  logic             rst_n,
   input  logic             cs_out,
   input  logic             start,
   output logic             busy,
   output logic [1:0]       filter,
   output logic [1:0]       cs_scaler,
   output logic [1:0]       color,
   output logic [CNT_W-1:0] red_cnt,
   output logic [CNT_W-1:0] green_cnt,
   output logic [CNT_W-1:0] blue_cnt,
   output logic             result_valid,
   input  logic             result_ack
);

`ifdef CS_AUTO_PWRDN_EN
   localparam int unsigned FIRST_SETTLE = 4 * SETTLE;
   localparam logic [1:0]  SCALER_RST   = 2'b00;
`else
   localparam int unsigned FIRST_SETTLE = SETTLE;
   localparam logic [1:0]  SCALER_RST   = 2'b11;
`endif

   localparam int unsigned TMAX = (WINDOW > FIRST_SETTLE) ? WINDOW : FIRST_SETTLE;
   localparam int unsigned TW   = $clog2(TMAX);

   localparam logic [TW-1:0]    T_WIN   = TW'(WINDOW - 1);
   localparam logic [TW-1:0]    T_SET   = TW'(SETTLE - 1);
   localparam logic [TW-1:0]    T_FIRST = TW'(FIRST_SETTLE - 1);
   localparam logic [CNT_W-1:0] C_MIN   = CNT_W'(MIN_CNT);

   localparam logic [1:0] F_RED   = 2'b00;
   localparam logic [1:0] F_BLUE  = 2'b01;
   localparam logic [1:0] F_CLEAR = 2'b10;
   localparam logic [1:0] F_GREEN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_COUNT,
      S_DECIDE,
      S_RESULT
   } state_t;

   typedef enum logic [1:0] {
      CH_R = 2'd0,
      CH_G = 2'd1,
      CH_B = 2'd2
   } ch_t;

   state_t           r_state;
   ch_t              r_ch;
   logic [TW-1:0]    r_timer;
   logic [CNT_W-1:0] r_acc_r, r_acc_g, r_acc_b;
   logic [CNT_W-1:0] r_red_cnt, r_green_cnt, r_blue_cnt;
   logic [1:0]       r_color;
   logic [1:0]       r_filter;
   logic [1:0]       r_scaler;
   logic             r_busy;
   logic             r_valid;

   logic             r_sync1, r_sync2, r_prev;
   logic             w_edge;
   logic             w_launch;
   logic [1:0]       w_color;
   logic [1:0]       w_ch_filter;

   // ---------------------------------------------------------------------------
   // cs_out synchroniser and rising-edge detect
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= cs_out;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_edge = r_sync2 & ~r_prev;

   // A new measurement starts from IDLE, or from RESULT when the consumer
   // acknowledges and requests again in the same cycle (back-to-back restart).
   // Ack is only honoured once result_valid is visible to the consumer.
   assign w_launch = ((r_state == S_IDLE) && start) ||
                     ((r_state == S_RESULT) && r_valid && result_ack && start);

   always_comb begin
      w_ch_filter = F_CLEAR;
      case (r_ch)
         CH_R:    w_ch_filter = F_RED;
         CH_G:    w_ch_filter = F_GREEN;
         CH_B:    w_ch_filter = F_BLUE;
         default: w_ch_filter = F_CLEAR;
      endcase
   end

   // The winner must be strictly greater than both other counts, so at most
   // one branch can ever match.
   always_comb begin
      w_color = 2'd0;
      if ((r_acc_r > r_acc_g) && (r_acc_r > r_acc_b) && (r_acc_r >= C_MIN))
         w_color = 2'd1;
      else if ((r_acc_g > r_acc_r) && (r_acc_g > r_acc_b) && (r_acc_g >= C_MIN))
         w_color = 2'd2;
      else if ((r_acc_b > r_acc_r) && (r_acc_b > r_acc_g) && (r_acc_b >= C_MIN))
         w_color = 2'd3;
   end

   // ---------------------------------------------------------------------------
   // Sequencer. The outputs are registered decodes of the current state, so
   // they trail the state register by one cycle. busy, filter and cs_scaler
   // therefore move one cycle after start is accepted, and result_valid rises
   // one cycle after DECIDE. The result registers are loaded before that.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ch        <= CH_R;
         r_timer     <= '0;
         r_acc_r     <= '0;
         r_acc_g     <= '0;
         r_acc_b     <= '0;
         r_red_cnt   <= '0;
         r_green_cnt <= '0;
         r_blue_cnt  <= '0;
         r_color     <= '0;
         r_filter    <= F_CLEAR;
         r_scaler    <= SCALER_RST;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_busy   <= (r_state == S_SETTLE) || (r_state == S_COUNT) || (r_state == S_DECIDE);
         r_valid  <= (r_state == S_RESULT);
         r_filter <= ((r_state == S_SETTLE) || (r_state == S_COUNT)) ? w_ch_filter : F_CLEAR;
`ifdef CS_AUTO_PWRDN_EN
         r_scaler <= ((r_state == S_SETTLE) || (r_state == S_COUNT) || (r_state == S_DECIDE))
                     ? 2'b11 : 2'b00;
`else
         r_scaler <= 2'b11;
`endif

         if (w_launch) begin
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
            r_ch    <= CH_R;
            r_timer <= T_FIRST;
            r_state <= S_SETTLE;
         end else begin
            case (r_state)
               S_IDLE: ;

               S_SETTLE: begin
                  if (r_timer == '0) begin
                     r_timer <= T_WIN;
                     r_state <= S_COUNT;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end

               S_COUNT: begin
                  if (w_edge) begin
                     case (r_ch)
                        CH_R:    if (r_acc_r != '1) r_acc_r <= r_acc_r + 1'b1;
                        CH_G:    if (r_acc_g != '1) r_acc_g <= r_acc_g + 1'b1;
                        CH_B:    if (r_acc_b != '1) r_acc_b <= r_acc_b + 1'b1;
                        default: ;
                     endcase
                  end
                  if (r_timer == '0) begin
                     case (r_ch)
                        CH_R: begin
                           r_ch    <= CH_G;
                           r_timer <= T_SET;
                           r_state <= S_SETTLE;
                        end
                        CH_G: begin
                           r_ch    <= CH_B;
                           r_timer <= T_SET;
                           r_state <= S_SETTLE;
                        end
                        default: r_state <= S_DECIDE;
                     endcase
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end

               S_DECIDE: begin
                  r_color     <= w_color;
                  r_red_cnt   <= r_acc_r;
                  r_green_cnt <= r_acc_g;
                  r_blue_cnt  <= r_acc_b;
                  r_state     <= S_RESULT;
               end

               S_RESULT: begin
                  if (r_valid && result_ack) r_state <= S_IDLE;
               end

               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy         = r_busy;
   assign filter       = r_filter;
   assign cs_scaler    = r_scaler;
   assign color        = r_color;
   assign red_cnt      = r_red_cnt;
   assign green_cnt    = r_green_cnt;
   assign blue_cnt     = r_blue_cnt;
   assign result_valid = r_valid;

endmodule

// File: tb/tb_cs_measure_sequencer.sv
`timescale 1ns/1ps
module tb_cs_measure_sequencer;

`ifdef CS_AUTO_PWRDN_EN
   localparam int         XS      = 24;
   localparam logic [1:0] SC_IDLE = 2'b00;
`else
   localparam int         XS      = 0;
   localparam logic [1:0] SC_IDLE = 2'b11;
`endif
   localparam int LAT = 1562 + XS;

   logic clk_1MHz   = 1'b0;
   logic rst_n      = 1'b0;
   logic cs_out     = 1'b0;
   logic start      = 1'b0;
   logic result_ack = 1'b0;

   logic       busy, result_valid;
   logic [1:0] filter, cs_scaler, color;
   logic [9:0] red_cnt, green_cnt, blue_cnt;

   logic       busy4, result_valid4;
   logic [1:0] filter4, cs_scaler4, color4;
   logic [3:0] red_cnt4, green_cnt4, blue_cnt4;

   int cyc     = 0;
   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int k;
      int col;
      int r;
      int g;
      int b;
   } exp_t;

   typedef struct {
      int nr, ng, nb, col;
      int r4, g4, b4, col4;
      bit settle_only;
   } vec_t;

   exp_t q_main[$];
   exp_t q_sat[$];
   vec_t vecs[7];

   cs_measure_sequencer #(
      .WINDOW(512), .SETTLE(8), .CNT_W(10), .MIN_CNT(15)
   ) dut (
      .clk_1MHz(clk_1MHz), .rst_n(rst_n), .cs_out(cs_out), .start(start),
      .busy(busy), .filter(filter), .cs_scaler(cs_scaler), .color(color),
      .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
      .result_valid(result_valid), .result_ack(result_ack)
   );

   cs_measure_sequencer #(
      .WINDOW(512), .SETTLE(8), .CNT_W(4), .MIN_CNT(15)
   ) dut_sat (
      .clk_1MHz(clk_1MHz), .rst_n(rst_n), .cs_out(cs_out), .start(start),
      .busy(busy4), .filter(filter4), .cs_scaler(cs_scaler4), .color(color4),
      .red_cnt(red_cnt4), .green_cnt(green_cnt4), .blue_cnt(blue_cnt4),
      .result_valid(result_valid4), .result_ack(result_ack)
   );

   always #5 clk_1MHz = ~clk_1MHz;
   always @(posedge clk_1MHz) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Returns at a negedge once edge number t has occurred.
   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk_1MHz);
   endtask

   task automatic launch(output int k);
      start = 1'b1;
      k = cyc + 1;
      wait_cyc(k);
      start = 1'b0;
   endtask

   task automatic push(input int idx, input int k);
      exp_t e;
      e.k = k; e.col = vecs[idx].col;
      e.r = vecs[idx].nr; e.g = vecs[idx].ng; e.b = vecs[idx].nb;
      q_main.push_back(e);
      e.col = vecs[idx].col4;
      e.r = vecs[idx].r4; e.g = vecs[idx].g4; e.b = vecs[idx].b4;
      q_sat.push_back(e);
   endtask

   // Each pulse rises just before edge t0+4i and is counted two edges later.
   task automatic pulses(input int t0, input int n);
      for (int i = 0; i < n; i++) begin
         wait_cyc(t0 + 4*i - 1); cs_out = 1'b1;
         wait_cyc(t0 + 4*i + 1); cs_out = 1'b0;
      end
   endtask

   task automatic wait_result(input int k);
      while (!result_valid && cyc < k + LAT + 50) @(negedge clk_1MHz);
      check("result_valid_seen", int'(result_valid), 1);
   endtask

   task automatic measure(input int idx, input int k, input bit mid_start);
      push(idx, k);
      if (vecs[idx].settle_only) begin
         pulses(k + 1, 2);
         pulses(k + XS + 520, 2);
         pulses(k + XS + 1040, 2);
      end else begin
         pulses(k + XS + 20, vecs[idx].nr);
         pulses(k + XS + 540, vecs[idx].ng);
         if (mid_start) begin
            wait_cyc(k + XS + 700);
            check("filter_green", int'(filter), 3);
            start = 1'b1;
            wait_cyc(k + XS + 701);
            start = 1'b0;
         end
         pulses(k + XS + 1060, vecs[idx].nb);
         if (mid_start) check("filter_blue", int'(filter), 1);
      end
      wait_result(k);
   endtask

   task automatic ack_plain();
      int a;
      result_ack = 1'b1;
      a = cyc + 1;
      wait_cyc(a);
      result_ack = 1'b0;
      wait_cyc(a + 1);
      check("valid_drop_after_ack", int'(result_valid), 0);
      check("busy_idle_after_ack", int'(busy), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_filter"}, int'(filter), 2);
      check({tag, "_scaler"}, int'(cs_scaler), int'(SC_IDLE));
      check({tag, "_color"}, int'(color), 0);
      check({tag, "_red"}, int'(red_cnt), 0);
      check({tag, "_green"}, int'(green_cnt), 0);
      check({tag, "_blue"}, int'(blue_cnt), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_valid"}, int'(result_valid), 0);
      check({tag, "_sat_valid"}, int'(result_valid4), 0);
   endtask

   // Scoreboard monitor, main instance
   initial begin : mon_main
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk_1MHz);
         if (result_valid && !prev) begin
            if (q_main.size() == 0) check("main_unexpected_result", 1, 0);
            else begin
               e = q_main.pop_front();
               check("main_latency", cyc - e.k, LAT);
               check("main_color", int'(color), e.col);
               check("main_red_cnt", int'(red_cnt), e.r);
               check("main_green_cnt", int'(green_cnt), e.g);
               check("main_blue_cnt", int'(blue_cnt), e.b);
               check("main_busy_at_valid", int'(busy), 0);
               check("main_scaler_at_valid", int'(cs_scaler), int'(SC_IDLE));
            end
         end
         prev = result_valid;
      end
   end

   // Scoreboard monitor, CNT_W=4 instance
   initial begin : mon_sat
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk_1MHz);
         if (result_valid4 && !prev) begin
            if (q_sat.size() == 0) check("sat_unexpected_result", 1, 0);
            else begin
               e = q_sat.pop_front();
               check("sat_latency", cyc - e.k, LAT);
               check("sat_color", int'(color4), e.col);
               check("sat_red_cnt", int'(red_cnt4), e.r);
               check("sat_green_cnt", int'(green_cnt4), e.g);
               check("sat_blue_cnt", int'(blue_cnt4), e.b);
            end
         end
         prev = result_valid4;
      end
   end

   initial begin : watchdog
      #(1_000_000);
      $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin : stim
      int k, a, diffs;
      logic [35:0] snap;

      //              nr  ng  nb col  r4  g4  b4 col4 settle_only
      vecs[0] = '{40, 10, 10, 1, 15, 10, 10, 1, 1'b0};
      vecs[1] = '{20, 20,  5, 0, 15, 15,  5, 0, 1'b0};
      vecs[2] = '{12,  3,  3, 0, 12,  3,  3, 0, 1'b0};
      vecs[3] = '{25, 30, 16, 2, 15, 15, 15, 0, 1'b0};
      vecs[4] = '{ 5,  6, 50, 3,  5,  6, 15, 3, 1'b0};
      vecs[5] = '{ 0,  0,  0, 0,  0,  0,  0, 0, 1'b1};
      vecs[6] = '{20,  0,  0, 1, 15,  0,  0, 1, 1'b0};

      repeat (3) @(negedge clk_1MHz);
      check_reset("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk_1MHz);

      // Dominant red, with an ignored start pulse during COUNT(G)
      launch(k);
      check("busy_at_k", int'(busy), 0);
      wait_cyc(k + 1);
      check("busy_at_k1", int'(busy), 1);
      check("filter_red_at_k1", int'(filter), 0);
      check("scaler_at_k1", int'(cs_scaler), 3);
      measure(0, k, 1'b1);

      // Result must hold while unacknowledged
      snap  = {color, red_cnt, green_cnt, blue_cnt, result_valid, busy, filter};
      diffs = 0;
      repeat (100) begin
         @(negedge clk_1MHz);
         if ({color, red_cnt, green_cnt, blue_cnt, result_valid, busy, filter} != snap)
            diffs++;
      end
      check("hold_stable_changes", diffs, 0);

      // Back-to-back restart: ack and start together
      result_ack = 1'b1;
      start      = 1'b1;
      a = cyc + 1;
      wait_cyc(a);
      result_ack = 1'b0;
      start      = 1'b0;
      wait_cyc(a + 1);
      check("b2b_busy", int'(busy), 1);
      check("b2b_valid", int'(result_valid), 0);
      check("b2b_filter", int'(filter), 0);
      measure(1, a, 1'b0);
      ack_plain();

      // Below minimum count
      launch(k);
      measure(2, k, 1'b0);
      ack_plain();

      // Asynchronous reset mid COUNT(B)
      launch(k);
      pulses(k + XS + 20, 10);
      wait_cyc(k + XS + 1200);
      #2 rst_n = 1'b0;
      #1 check_reset("async_rst");
      @(negedge clk_1MHz);
      @(negedge clk_1MHz);
      rst_n = 1'b1;
      @(negedge clk_1MHz);

      launch(k);
      measure(3, k, 1'b0);
      ack_plain();

      launch(k);
      measure(4, k, 1'b0);
      ack_plain();

      // Edges only during settle periods
      launch(k);
      measure(5, k, 1'b0);
      ack_plain();

      // Saturation on the CNT_W=4 instance
      launch(k);
      measure(6, k, 1'b0);
      ack_plain();

      repeat (10) @(negedge clk_1MHz);
      check("main_queue_empty", q_main.size(), 0);
      check("sat_queue_empty", q_sat.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
